// File: rtl/mc_control_pkg.sv
// Shared constants for the multi-cycle TSC control unit:
// opcodes, funcs, FSM states and datapath mux encodings.
package mc_control_pkg;

  localparam logic [3:0] OP_BNE = 4'd0;
  localparam logic [3:0] OP_BEQ = 4'd1;
  localparam logic [3:0] OP_BGZ = 4'd2;
  localparam logic [3:0] OP_BLZ = 4'd3;
  localparam logic [3:0] OP_ADI = 4'd4;
  localparam logic [3:0] OP_ORI = 4'd5;
  localparam logic [3:0] OP_LHI = 4'd6;
  localparam logic [3:0] OP_LWD = 4'd7;
  localparam logic [3:0] OP_SWD = 4'd8;
  localparam logic [3:0] OP_JMP = 4'd9;
  localparam logic [3:0] OP_JAL = 4'd10;
  localparam logic [3:0] OP_R   = 4'd15;

  localparam int F_ALU_LAST = 7;
  localparam int F_JPR      = 25;
  localparam int F_JRL      = 26;
  localparam int F_WWD      = 28;
  localparam int F_HLT      = 29;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  localparam logic [1:0] PC_NEXT = 2'd0;
  localparam logic [1:0] PC_BR   = 2'd1;
  localparam logic [1:0] PC_JMP  = 2'd2;
  localparam logic [1:0] PC_REG  = 2'd3;

  localparam logic [1:0] RD_RT   = 2'd0;
  localparam logic [1:0] RD_RD   = 2'd1;
  localparam logic [1:0] RD_LINK = 2'd2;

  localparam logic [1:0] WS_ALU  = 2'd0;
  localparam logic [1:0] WS_MEM  = 2'd1;
  localparam logic [1:0] WS_PC   = 2'd2;

  typedef struct packed {
    logic branch;
    logic jump;
    logic jump_reg;
    logic link;
    logic alu_r;
    logic alu_i;
    logic load;
    logic store;
    logic wwd;
    logic hlt;
    logic undef;
  } inst_class_t;

endpackage

// File: rtl/mc_control_decode.sv
// Combinational field decode of the latched IR:
// instruction class plus ALU controls.
module mc_control_decode
  import mc_control_pkg::*;
#(
  parameter int FUNC_WIDTH = 6
) (
  input  logic [3:0]            i_op,
  input  logic [FUNC_WIDTH-1:0] i_func,
  output inst_class_t           o_cls,
  output logic [2:0]            o_alu_op,
  output logic                  o_alu_src,
  output logic                  o_is_lhi
);

  // classify opcode/func into one class
  always_comb begin
    o_cls     = '0;
    o_alu_op  = 3'd0;
    o_alu_src = 1'b0;
    o_is_lhi  = 1'b0;
    case (i_op)
      OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: o_cls.branch = 1'b1;
      OP_ADI: begin
        o_cls.alu_i = 1'b1;
        o_alu_op    = 3'd3;
        o_alu_src   = 1'b1;
      end
      OP_ORI: begin
        o_cls.alu_i = 1'b1;
        o_alu_op    = 3'd2;
        o_alu_src   = 1'b1;
      end
      OP_LHI: begin
        o_cls.alu_i = 1'b1;
        o_alu_src   = 1'b1;
        o_is_lhi    = 1'b1;
      end
      OP_LWD: begin
        o_cls.load = 1'b1;
        o_alu_op   = 3'd3;
        o_alu_src  = 1'b1;
      end
      OP_SWD: begin
        o_cls.store = 1'b1;
        o_alu_op    = 3'd3;
        o_alu_src   = 1'b1;
      end
      OP_JMP: o_cls.jump = 1'b1;
      OP_JAL: begin
        o_cls.jump = 1'b1;
        o_cls.link = 1'b1;
      end
      OP_R: begin
        unique case (1'b1)
          (i_func <= FUNC_WIDTH'(F_ALU_LAST)): begin
            o_cls.alu_r = 1'b1;
            o_alu_op    = i_func[2:0];
          end
          (i_func == FUNC_WIDTH'(F_JPR)):
            o_cls.jump_reg = 1'b1;
          (i_func == FUNC_WIDTH'(F_JRL)): begin
            o_cls.jump_reg = 1'b1;
            o_cls.link     = 1'b1;
          end
          (i_func == FUNC_WIDTH'(F_WWD)):
            o_cls.wwd = 1'b1;
          (i_func == FUNC_WIDTH'(F_HLT)):
            o_cls.hlt = 1'b1;
          default: o_cls.undef = 1'b1;
        endcase
      end
      default: o_cls.undef = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle TSC control FSM with memory handshake,
// access timeout and retired-instruction counter.
module mc_control
  import mc_control_pkg::*;
#(
  parameter int WORD_SIZE      = 16,
  parameter int FUNC_WIDTH     = 6,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] inst,
  input  logic                 inst_valid,
  input  logic                 data_ready,
  input  logic                 branch_cond,
  output logic                 i_read_req,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic                 reg_write,
  output logic [1:0]           reg_dest,
  output logic [1:0]           reg_write_src,
  output logic [2:0]           alu_op,
  output logic                 alu_src,
  output logic                 is_lhi,
  output logic                 d_read_req,
  output logic                 d_write_req,
  output logic                 output_port_write,
  output logic                 is_halted,
  output logic                 timeout_err,
  output logic [WORD_SIZE-1:0] num_inst,
  output logic [2:0]           state
);

  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_op;
  logic [FUNC_WIDTH-1:0] r_func;
  logic [WW-1:0]         r_wait;
  logic [WW-1:0]         w_wait_inc;
  logic [WORD_SIZE-1:0]  r_num;
  logic                  w_retire;
  logic                  w_wait;
  inst_class_t           w_cls;
  logic [2:0]            w_alu_op;
  logic                  w_alu_src;
  logic                  w_is_lhi;
  logic                  w_unused_ir;

  // register operands live in the datapath IR
  assign w_unused_ir =
    &{1'b0, inst[WORD_SIZE-5:FUNC_WIDTH]};

  assign w_wait_inc = r_wait + 1'b1;
  assign state      = r_state;

  mc_control_decode #(
    .FUNC_WIDTH (FUNC_WIDTH)
  ) u_decode (
    .i_op      (r_op),
    .i_func    (r_func),
    .o_cls     (w_cls),
    .o_alu_op  (w_alu_op),
    .o_alu_src (w_alu_src),
    .o_is_lhi  (w_is_lhi)
  );

  // state register
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_FETCH;
    else          r_state <= w_next;
  end

  // IR fields, wait counter and retire counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_op   <= '0;
      r_func <= '0;
      r_wait <= '0;
      r_num  <= '0;
    end else begin
      if (r_state == S_FETCH && inst_valid) begin
        r_op   <= inst[WORD_SIZE-1 -: 4];
        r_func <= inst[FUNC_WIDTH-1:0];
      end
      if (w_next != r_state) r_wait <= '0;
      else if (w_wait)       r_wait <= w_wait_inc;
      if (w_retire) r_num <= r_num + 1'b1;
    end
  end

  // next state, retire and wait decisions
  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    w_wait   = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        if (inst_valid) begin
          w_next = S_DECODE;
        end else begin
          w_wait = 1'b1;
          if (w_wait_inc == WW'(TIMEOUT_CYCLES))
            w_next = S_ERROR;
        end
      end
      S_DECODE: begin
        if (w_cls.hlt) begin
          w_next   = S_HALT;
          w_retire = 1'b1;
        end else if (w_cls.jump | w_cls.jump_reg |
                     w_cls.wwd | w_cls.undef) begin
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_cls.branch) begin
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end else if (w_cls.load | w_cls.store) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        if (data_ready) begin
          if (w_cls.load) begin
            w_next = S_WB;
          end else begin
            w_next   = S_FETCH;
            w_retire = 1'b1;
          end
        end else begin
          w_wait = 1'b1;
          if (w_wait_inc == WW'(TIMEOUT_CYCLES))
            w_next = S_ERROR;
        end
      end
      S_WB: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      S_HALT:  w_next = S_HALT;
      S_ERROR: w_next = S_ERROR;
      default: w_next = S_FETCH;
    endcase
  end

  // per-state control outputs, all zero in reset
  always_comb begin
    i_read_req        = 1'b0;
    ir_write          = 1'b0;
    pc_write          = 1'b0;
    pc_src            = PC_NEXT;
    reg_write         = 1'b0;
    reg_dest          = RD_RT;
    reg_write_src     = WS_ALU;
    alu_op            = 3'd0;
    alu_src           = 1'b0;
    is_lhi            = 1'b0;
    d_read_req        = 1'b0;
    d_write_req       = 1'b0;
    output_port_write = 1'b0;
    is_halted         = 1'b0;
    timeout_err       = 1'b0;
    num_inst          = '0;
    if (reset_n) begin
      num_inst = r_num;
      if (r_state == S_EXEC || r_state == S_MEM ||
          r_state == S_WB) begin
        alu_op  = w_alu_op;
        alu_src = w_alu_src;
        is_lhi  = w_is_lhi;
      end
      unique case (r_state)
        S_FETCH: begin
          i_read_req = 1'b1;
          ir_write   = inst_valid;
        end
        S_DECODE: begin
          unique case (1'b1)
            w_cls.jump: begin
              pc_write = 1'b1;
              pc_src   = PC_JMP;
            end
            w_cls.jump_reg: begin
              pc_write = 1'b1;
              pc_src   = PC_REG;
            end
            w_cls.wwd: begin
              pc_write          = 1'b1;
              output_port_write = 1'b1;
            end
            w_cls.undef: pc_write = 1'b1;
            default: ;
          endcase
          if (w_cls.link) begin
            reg_write     = 1'b1;
            reg_dest      = RD_LINK;
            reg_write_src = WS_PC;
          end
        end
        S_EXEC: begin
          if (w_cls.branch) begin
            pc_write = 1'b1;
            pc_src   = branch_cond ? PC_BR : PC_NEXT;
          end
        end
        S_MEM: begin
          d_read_req  = w_cls.load;
          d_write_req = w_cls.store;
          pc_write    = w_cls.store & data_ready;
        end
        S_WB: begin
          reg_write     = 1'b1;
          pc_write      = 1'b1;
          reg_dest      = w_cls.alu_r ? RD_RD : RD_RT;
          reg_write_src = w_cls.load ? WS_MEM : WS_ALU;
        end
        S_HALT:  is_halted   = 1'b1;
        S_ERROR: timeout_err = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: instruction flows,
// handshake stalls, halt, timeout and reset.
module tb_mc_control;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] inst;
  logic        inst_valid;
  logic        data_ready;
  logic        branch_cond;
  logic        i_read_req;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        reg_write;
  logic [1:0]  reg_dest;
  logic [1:0]  reg_write_src;
  logic [2:0]  alu_op;
  logic        alu_src;
  logic        is_lhi;
  logic        d_read_req;
  logic        d_write_req;
  logic        output_port_write;
  logic        is_halted;
  logic        timeout_err;
  logic [15:0] num_inst;
  logic [2:0]  state;

  int checks   = 0;
  int failures = 0;
  int hold;

  always #5 clk = ~clk;

  mc_control dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .inst              (inst),
    .inst_valid        (inst_valid),
    .data_ready        (data_ready),
    .branch_cond       (branch_cond),
    .i_read_req        (i_read_req),
    .ir_write          (ir_write),
    .pc_write          (pc_write),
    .pc_src            (pc_src),
    .reg_write         (reg_write),
    .reg_dest          (reg_dest),
    .reg_write_src     (reg_write_src),
    .alu_op            (alu_op),
    .alu_src           (alu_src),
    .is_lhi            (is_lhi),
    .d_read_req        (d_read_req),
    .d_write_req       (d_write_req),
    .output_port_write (output_port_write),
    .is_halted         (is_halted),
    .timeout_err       (timeout_err),
    .num_inst          (num_inst),
    .state             (state)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // wait `dly` idle FETCH cycles, then present instr;
  // returns one cycle into DECODE
  task automatic fetch(input logic [15:0] instr,
                       input int dly);
    inst_valid = 1'b0;
    for (int i = 0; i < dly; i++) step();
    inst       = instr;
    inst_valid = 1'b1;
    #1;
    chk("ir_write", ir_write, 1);
    step();
    inst_valid = 1'b0;
    #1;
  endtask

  initial begin
    reset_n     = 1'b0;
    inst        = 16'h0000;
    inst_valid  = 1'b0;
    data_ready  = 1'b0;
    branch_cond = 1'b0;
    step();
    step();
    chk("rst_state", state, 0);
    chk("rst_ireq", i_read_req, 0);
    chk("rst_num", num_inst, 0);
    chk("rst_halt", is_halted, 0);
    reset_n = 1'b1;
    #1;
    chk("fetch_ireq", i_read_req, 1);

    // ADI $1,$0,5 with one idle fetch cycle
    step();
    chk("adi_s0b", state, 0);
    inst       = 16'h4105;
    inst_valid = 1'b1;
    #1;
    chk("adi_irw", ir_write, 1);
    step();
    inst_valid = 1'b0;
    #1;
    chk("adi_s1", state, 1);
    chk("adi_dec_pcw", pc_write, 0);
    step();
    chk("adi_s2", state, 2);
    chk("adi_aluop", alu_op, 3);
    chk("adi_alusrc", alu_src, 1);
    step();
    chk("adi_s4", state, 4);
    chk("adi_regw", reg_write, 1);
    chk("adi_rdest", reg_dest, 0);
    chk("adi_wsrc", reg_write_src, 0);
    chk("adi_pcw", pc_write, 1);
    step();
    chk("adi_s0", state, 0);
    chk("adi_num", num_inst, 1);

    // LWD with data_ready after three stall cycles
    fetch(16'h7600, 0);
    step();
    chk("lwd_exec", state, 2);
    step();
    hold = 0;
    for (int i = 0; i < 3; i++) begin
      if (d_read_req) hold++;
      step();
    end
    data_ready = 1'b1;
    #1;
    chk("lwd_mem", state, 3);
    if (d_read_req) hold++;
    chk("lwd_hold", hold, 4);
    step();
    data_ready = 1'b0;
    #1;
    chk("lwd_wb", state, 4);
    chk("lwd_wsrc", reg_write_src, 1);
    chk("lwd_regw", reg_write, 1);
    chk("lwd_rdq", d_read_req, 0);
    step();
    chk("lwd_num", num_inst, 2);

    // BEQ taken then not taken
    fetch(16'h1103, 0);
    step();
    branch_cond = 1'b1;
    #1;
    chk("beq_t_pcw", pc_write, 1);
    chk("beq_t_src", pc_src, 1);
    step();
    chk("beq_t_s0", state, 0);
    chk("beq_t_num", num_inst, 3);
    fetch(16'h1103, 0);
    step();
    branch_cond = 1'b0;
    #1;
    chk("beq_n_pcw", pc_write, 1);
    chk("beq_n_src", pc_src, 0);
    step();
    chk("beq_n_s0", state, 0);
    chk("beq_n_num", num_inst, 4);

    // JAL 0x123
    fetch(16'hA123, 0);
    chk("jal_src", pc_src, 2);
    chk("jal_pcw", pc_write, 1);
    chk("jal_regw", reg_write, 1);
    chk("jal_rdest", reg_dest, 2);
    chk("jal_wsrc", reg_write_src, 2);
    step();
    chk("jal_s0", state, 0);
    chk("jal_num", num_inst, 5);

    // WWD $1
    fetch(16'hF41C, 0);
    chk("wwd_out", output_port_write, 1);
    chk("wwd_pcw", pc_write, 1);
    chk("wwd_regw", reg_write, 0);
    step();
    chk("wwd_num", num_inst, 6);

    // ADD $3,$1,$2 (R-type)
    fetch(16'hF6C0, 0);
    chk("add_dec_pcw", pc_write, 0);
    step();
    chk("add_exec", state, 2);
    chk("add_alusrc", alu_src, 0);
    step();
    chk("add_rdest", reg_dest, 1);
    step();
    chk("add_num", num_inst, 7);

    // SWD with immediate data_ready
    fetch(16'h8600, 0);
    step();
    step();
    data_ready = 1'b1;
    #1;
    chk("swd_wreq", d_write_req, 1);
    chk("swd_pcw", pc_write, 1);
    step();
    data_ready = 1'b0;
    #1;
    chk("swd_s0", state, 0);
    chk("swd_num", num_inst, 8);

    // undefined opcode 12 acts as NOP
    fetch(16'hC000, 0);
    chk("undef_pcw", pc_write, 1);
    chk("undef_src", pc_src, 0);
    step();
    chk("undef_s0", state, 0);
    chk("undef_num", num_inst, 9);

    // HLT arriving on the 15th wait cycle beats timeout
    fetch(16'hF01D, 14);
    chk("hlt_dec", state, 1);
    chk("hlt_not_yet", is_halted, 0);
    step();
    chk("hlt_state", state, 5);
    chk("hlt_flag", is_halted, 1);
    chk("hlt_num", num_inst, 10);
    for (int i = 0; i < 4; i++) begin
      inst_valid = i[0];
      data_ready = ~i[0];
      step();
    end
    inst_valid = 1'b0;
    data_ready = 1'b0;
    #1;
    chk("hlt_sticky", is_halted, 1);
    chk("hlt_ireq", i_read_req, 0);
    chk("hlt_frozen", num_inst, 10);

    // fetch timeout into ERROR
    reset_n = 1'b0;
    step();
    chk("rst2_halt", is_halted, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 14; i++) step();
    chk("to_s14", state, 0);
    step();
    chk("to_state", state, 6);
    chk("to_err", timeout_err, 1);
    chk("to_ireq", i_read_req, 0);
    step();
    step();
    chk("to_sticky", state, 6);

    // reset in the middle of a LWD access
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    fetch(16'h7600, 0);
    step();
    step();
    chk("rm_rreq", d_read_req, 1);
    reset_n = 1'b0;
    #1;
    chk("rm_drop", d_read_req, 0);
    step();
    reset_n = 1'b1;
    #1;
    chk("rm_state", state, 0);
    chk("rm_num", num_inst, 0);
    chk("rm_ireq", i_read_req, 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multi-cycle successor to the single-cycle control decoder for the 16-bit TSC ISA.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states.
- Handshakes with a variable-latency instruction/data memory and times out stalled accesses.
- Counts retired instructions. Sits between the memory interface and the datapath (PC, IR, register file, ALU).

Parameters:
- WORD_SIZE, 16, instruction/data word width; also the width of num_inst.
- FUNC_WIDTH, 6, R-type function field width (inst[FUNC_WIDTH-1:0]).
- TIMEOUT_CYCLES, 15, maximum wait cycles for inst_valid/data_ready before ERROR; must be >=1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- inst  in  WORD_SIZE  instruction word from instruction memory; sampled when inst_valid=1 in FETCH.
- inst_valid  in  1  instruction memory has returned inst.
- data_ready  in  1  data memory has completed the read or write.
- branch_cond  in  1  datapath branch comparison result for the latched opcode.
- i_read_req  out  1  instruction fetch request.
- ir_write  out  1  latch inst into the datapath IR.
- pc_write  out  1  update PC this cycle.
- pc_src  out  2  0 = PC+1, 1 = PC+1+sign-extended imm8, 2 = jump target {PC[15:12],inst[11:0]}, 3 = register rs.
- reg_write  out  1  register file write enable.
- reg_dest  out  2  0 = rt, 1 = rd, 2 = $2 (link).
- reg_write_src  out  2  0 = ALU, 1 = memory data, 2 = PC+1.
- alu_op  out  3  ALU operation: R-type func[2:0]; 3 for ADI/LWD/SWD; 2 for ORI.
- alu_src  out  1  0 = register, 1 = immediate.
- is_lhi  out  1  LHI immediate path.
- d_read_req  out  1  data memory read request.
- d_write_req  out  1  data memory write request.
- output_port_write  out  1  WWD output latch strobe.
- is_halted  out  1  HLT retired; sticky.
- timeout_err  out  1  memory timeout occurred; sticky.
- num_inst  out  WORD_SIZE  retired-instruction counter.
- state  out  3  current FSM state, for debug.

Behaviour:
- reset_n=0 at an edge: state <= FETCH, num_inst <= 0, wait counter <= 0, latched IR <= 0, is_halted/timeout_err <= 0. While reset_n=0, all outputs except state are forced to 0. Reset applied in any state, including MEM mid-handshake, drops requests immediately.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, ERROR=6.
- Outputs are combinational from state, latched IR and the current handshake input. Every strobe (ir_write, pc_write, reg_write, output_port_write) lasts exactly one cycle per instruction.
- FETCH:
  - i_read_req=1.
  - If inst_valid: ir_write=1, latch inst, go DECODE.
  - Otherwise increment the wait counter. When the counter reaches TIMEOUT_CYCLES, go ERROR.
  - The wait counter clears on every state change.
- DECODE:
  - HLT (op 15, func 29): go HALT; is_halted=1 from the next cycle; counted as retired.
  - JMP (op 9): pc_write=1, pc_src=2.
  - JAL (op 10): as JMP, plus reg_write=1, reg_dest=2, reg_write_src=2.
  - JPR (func 25): pc_write=1, pc_src=3.
  - JRL (func 26): as JPR, plus link write as JAL.
  - WWD (func 28): output_port_write=1, pc_write=1, pc_src=0.
  - Undefined opcode 11-14 or unlisted func: NOP; pc_write=1, pc_src=0.
  - All of the above cases increment num_inst and return to FETCH.
  - Any other instruction: go EXEC.
- EXEC:
  - alu_op/alu_src/is_lhi are driven from the latched IR and held through MEM and WB. R-type: alu_src=0.
  - Branch (op 0-3): pc_write=1, pc_src = branch_cond ? 1 : 0; retire; go FETCH.
  - LWD/SWD: go MEM.
  - Others: go WB.
- MEM:
  - LWD holds d_read_req=1; SWD holds d_write_req=1, until data_ready.
  - On data_ready: LWD goes WB; SWD pulses pc_write (pc_src=0), retires and goes FETCH.
  - Timeout rule as in FETCH.
- WB:
  - reg_write=1, pc_write=1, pc_src=0; retire; go FETCH.
  - reg_dest: 1 for R-type, 0 for ADI/ORI/LHI/LWD.
  - reg_write_src: 1 for LWD, 0 otherwise.
- HALT: all strobes and requests 0. Remains in HALT until reset; inst_valid and data_ready are ignored.
- ERROR: timeout_err=1, all strobes and requests 0. Remains in ERROR until reset.
- num_inst wraps modulo 2^WORD_SIZE; 0xFFFF + 1 = 0.
- Simultaneous inst_valid and a timeout boundary: inst_valid wins.

Decomposition:
- Shared package/header (opcodes.v): opcode and func constants, state encodings, pc_src/reg_dest/reg_write_src encodings.
- Sub-module inst_field_decode: combinational; latched IR -> instruction class (branch, jump, jump-reg, link, ALU-R, ALU-I, load, store, WWD, HLT, undefined) plus alu_op.
- mc_control holds the FSM, the wait counter and num_inst.

Test Plan:
- ADI $1,$0,5 with inst_valid 1 cycle after request -> states 0,0,1,2,4,0; reg_write=1 in WB with reg_dest=0; num_inst=1.
- LWD with data_ready delayed 3 cycles -> d_read_req held 4 cycles; WB has reg_write_src=1; num_inst increments once.
- BEQ with branch_cond=1, then with branch_cond=0 -> pc_src=1 then 0, one pc_write each, 3 cycles per branch.
- JAL 0x123 -> in DECODE: pc_src=2, reg_dest=2, reg_write_src=2, reg_write=1; next state FETCH.
- HLT then inst_valid toggling -> is_halted=1 sticky; num_inst frozen; no requests.
- inst_valid never asserted -> ERROR after 15 wait cycles; timeout_err=1. reset_n=0 during MEM -> d_read_req=0 that cycle, FETCH after release, num_inst=0.
